sme_job_sched: RTL and testbench

SME_JOB_SCHED -- requirements
Module: sme_job_sched

---
 rtl/sme_job_sched.sv | 194 +++++++++++++++++++
 tb/tb_sme_job_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sme_job_sched.sv
// sme_job_sched: buffers a string and up to MAX_PAT patterns, replays the string plus one pattern per pass to a matching core, and returns one result per pattern.
module sme_job_sched #(
  parameter int STR_LENGTH = 32,
  parameter int PATTERN_LENGTH = 8,
  parameter int MAX_PAT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_data,
  input  logic       host_isstring,
  input  logic       host_ispattern,
  input  logic       host_patlast,
  input  logic       host_go,
  output logic       host_ready,
  output logic [7:0] core_chardata,
  output logic       core_isstring,
  output logic       core_ispattern,
  input  logic       core_valid,
  input  logic       core_match,
  input  logic [4:0] core_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_pat_id,
  output logic       res_timeout,
  output logic       done,
  output logic       overflow
);
  localparam int SW = $clog2(STR_LENGTH + 1);
  localparam int SA = $clog2(STR_LENGTH);
  localparam int LW = $clog2(PATTERN_LENGTH + 1);
  localparam int LA = $clog2(PATTERN_LENGTH);
  localparam int PW = $clog2(MAX_PAT + 1);
  localparam int PA = MAX_PAT > 1 ? $clog2(MAX_PAT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {LOAD, SEND_STR, SEND_PAT, GAP, WAIT_RES, PUSH_RES, FINISH} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   str_len_q, str_len_d, idx_q, idx_d;
  logic [PW-1:0]   pat_cnt_q, pat_cnt_d;
  logic [LW-1:0]   pat_len_q [MAX_PAT];
  logic [LW-1:0]   pat_len_d [MAX_PAT];
  logic [PA-1:0]   cur_q, cur_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            match_q, match_d, tout_q, tout_d, overflow_q, overflow_d;
  logic [4:0]      index_q, index_d;
  logic [7:0]      str_buf_q [STR_LENGTH];
  logic [7:0]      pat_buf_q [MAX_PAT][PATTERN_LENGTH];
  logic            str_we, pat_we, pat_full;
  logic [PA-1:0]   slot;
  logic [LW-1:0]   cur_len;

  assign slot     = pat_cnt_q[PA-1:0];
  assign pat_full = pat_cnt_q == PW'(MAX_PAT);
  assign cur_len  = pat_len_q[slot];

  always_comb begin
    state_d    = state_q;
    str_len_d  = str_len_q;
    pat_cnt_d  = pat_cnt_q;
    pat_len_d  = pat_len_q;
    cur_d      = cur_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    match_d    = match_q;
    index_d    = index_q;
    tout_d     = tout_q;
    overflow_d = overflow_q;
    str_we     = 1'b0;
    pat_we     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (host_isstring && host_ispattern) overflow_d = 1'b1;
        else if (host_isstring) begin
          if (str_len_q < SW'(STR_LENGTH)) begin
            str_we    = 1'b1;
            str_len_d = str_len_q + 1'b1;
          end else overflow_d = 1'b1;
        end else if (host_ispattern) begin
          if (pat_full) overflow_d = 1'b1;
          else begin
            if (cur_len < LW'(PATTERN_LENGTH)) begin
              pat_we          = 1'b1;
              pat_len_d[slot] = cur_len + 1'b1;
            end else overflow_d = 1'b1;
            // an empty pattern never becomes a job entry
            if (host_patlast && (pat_we || cur_len != '0)) pat_cnt_d = pat_cnt_q + 1'b1;
          end
        end
        if (host_go) begin
          overflow_d = 1'b0;
          idx_d      = '0;
          cur_d      = '0;
          state_d    = (str_len_d != '0 && pat_cnt_d != '0) ? SEND_STR : FINISH;
        end
      end
      SEND_STR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q + 1'b1 == str_len_q) begin
          idx_d   = '0;
          state_d = SEND_PAT;
        end
      end
      SEND_PAT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q + 1'b1 == SW'(pat_len_q[cur_q])) begin
          idx_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        tmr_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (core_valid) begin
          match_d = core_match;
          index_d = core_match_index;
          tout_d  = 1'b0;
          state_d = PUSH_RES;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          match_d = 1'b0;
          index_d = '0;
          tout_d  = 1'b1;
          state_d = PUSH_RES;
        end else tmr_d = tmr_q + 1'b1;
      end
      PUSH_RES: begin
        if (res_ready) begin
          state_d = (PW'(cur_q) + 1'b1 < pat_cnt_q) ? SEND_STR : FINISH;
          cur_d   = (PW'(cur_q) + 1'b1 < pat_cnt_q) ? cur_q + 1'b1 : cur_q;
          idx_d   = '0;
        end
      end
      FINISH: begin
        str_len_d = '0;
        pat_cnt_d = '0;
        pat_len_d = '{default: '0};
        cur_d     = '0;
        state_d   = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      str_len_q  <= '0;
      pat_cnt_q  <= '0;
      pat_len_q  <= '{default: '0};
      cur_q      <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      match_q    <= 1'b0;
      index_q    <= '0;
      tout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      str_len_q  <= str_len_d;
      pat_cnt_q  <= pat_cnt_d;
      pat_len_q  <= pat_len_d;
      cur_q      <= cur_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      match_q    <= match_d;
      index_q    <= index_d;
      tout_q     <= tout_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (str_we) str_buf_q[str_len_q[SA-1:0]] <= host_data;
    if (pat_we) pat_buf_q[slot][cur_len[LA-1:0]] <= host_data;
  end

  assign host_ready     = state_q == LOAD && !reset;
  assign core_isstring  = state_q == SEND_STR;
  assign core_ispattern = state_q == SEND_PAT;
  assign core_chardata  = core_isstring ? str_buf_q[idx_q[SA-1:0]] :
                          core_ispattern ? pat_buf_q[cur_q][idx_q[LA-1:0]] : 8'h00;
  assign res_valid      = state_q == PUSH_RES;
  assign res_match      = match_q;
  assign res_index      = index_q;
  assign res_pat_id     = 2'(cur_q);
  assign res_timeout    = tout_q;
  assign done           = state_q == FINISH;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_sme_job_sched.sv
// tb_sme_job_sched: directed vector table for a full job plus hand sequences for multi-pattern, overflow, timeout, empty-job and reset cases.
module tb_sme_job_sched;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_isstring = 1'b0, host_ispattern = 1'b0, host_patlast = 1'b0, host_go = 1'b0;
  logic       core_valid = 1'b0, core_match = 1'b0, res_ready = 1'b0;
  logic [4:0] core_match_index = 5'd0;
  logic       host_ready, core_isstring, core_ispattern, res_valid, res_match, res_timeout, done, overflow;
  logic [7:0] core_chardata;
  logic [4:0] res_index;
  logic [1:0] res_pat_id;

  int errs = 0, chks = 0;
  int n_str = 0, n_done = 0, n_rv = 0;

  always #5 clk = ~clk;

  sme_job_sched dut (
    .clk(clk), .reset(reset), .host_data(host_data), .host_isstring(host_isstring),
    .host_ispattern(host_ispattern), .host_patlast(host_patlast), .host_go(host_go),
    .host_ready(host_ready), .core_chardata(core_chardata), .core_isstring(core_isstring),
    .core_ispattern(core_ispattern), .core_valid(core_valid), .core_match(core_match),
    .core_match_index(core_match_index), .res_valid(res_valid), .res_ready(res_ready),
    .res_match(res_match), .res_index(res_index), .res_pat_id(res_pat_id),
    .res_timeout(res_timeout), .done(done), .overflow(overflow)
  );

  always @(posedge clk) begin
    if (core_isstring) n_str <= n_str + 1;
    if (done) n_done <= n_done + 1;
    if (res_valid) n_rv <= n_rv + 1;
  end

  typedef struct packed {
    logic [7:0]  d;
    logic        s, p, l, g, cv, cm;
    logic [4:0]  ci;
    logic        rr;
    logic [22:0] e;
  } vec_t;
  vec_t vt[$];

  function automatic logic [22:0] ex(input logic r, i, p, dn, input logic [7:0] c, input logic v, input logic [8:0] pl);
    return {r, i, p, dn, c, v, pl, 1'b0};
  endfunction

  function automatic vec_t v(input logic [7:0] d, input logic s, p, l, g, cv, cm, input logic [4:0] ci, input logic rr, input logic [22:0] e);
    return '{d, s, p, l, g, cv, cm, ci, rr, e};
  endfunction

  function automatic logic [22:0] obs();
    return {host_ready, core_isstring, core_ispattern, done, core_chardata, res_valid,
            res_valid ? {res_match, res_index, res_pat_id, res_timeout} : 9'd0, overflow};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drv(input logic [7:0] d, input logic s, p, l, g);
    host_data = d; host_isstring = s; host_ispattern = p; host_patlast = l; host_go = g;
    step();
    host_data = 8'h00; host_isstring = 1'b0; host_ispattern = 1'b0; host_patlast = 1'b0; host_go = 1'b0;
  endtask

  task automatic wait_rv(input string nm);
    int n = 0;
    while (!res_valid && n < 400) begin step(); n++; end
    chk(nm, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin step(); n++; end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic wait_pat(input string nm);
    int n = 0;
    while (!core_ispattern && n < 100) begin step(); n++; end
    chk(nm, 32'(core_ispattern), 32'd1);
  endtask

  initial begin
    logic [22:0] lidle, z;
    int s0, d0, r0, n;
    lidle = ex(1, 0, 0, 0, 8'h00, 0, 9'h0);
    z     = ex(0, 0, 0, 0, 8'h00, 0, 9'h0);
    vt.push_back(v(8'h61, 1, 0, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h62, 1, 0, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h20, 1, 0, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h63, 1, 0, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h64, 1, 0, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h63, 0, 1, 0, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h64, 0, 1, 1, 0, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h00, 0, 0, 0, 1, 0, 0, 5'd0, 0, lidle));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 1, 0, 0, 8'h61, 0, 9'h0)));
    vt.push_back(v(8'h7a, 1, 0, 0, 0, 1, 0, 5'd7, 0, ex(0, 1, 0, 0, 8'h62, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 1, 0, 0, 8'h20, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 1, 0, 0, 8'h63, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 1, 0, 0, 8'h64, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 0, 1, 0, 8'h63, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 0, 1, 0, 8'h64, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, z));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 1, 1, 5'd3, 0, z));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 1, ex(0, 0, 0, 0, 8'h00, 1, 9'b1_00011_00_0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, ex(0, 0, 0, 1, 8'h00, 0, 9'h0)));
    vt.push_back(v(8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, lidle));

    step(); step();
    chk("reset outputs", 32'(obs()), 32'd0);
    reset = 1'b0;
    #1 chk("ready after reset", 32'(host_ready), 32'd1);

    // single job "ab cd" / "cd", one row per cycle
    for (int i = 0; i < vt.size(); i++) begin
      {host_data, host_isstring, host_ispattern, host_patlast, host_go} = {vt[i].d, vt[i].s, vt[i].p, vt[i].l, vt[i].g};
      {core_valid, core_match, core_match_index, res_ready} = {vt[i].cv, vt[i].cm, vt[i].ci, vt[i].rr};
      #1 chk($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].e));
      step();
    end
    {host_data, host_isstring, host_ispattern, host_patlast, host_go} = '0;
    {core_valid, core_match, core_match_index, res_ready} = '0;

    // three patterns with back-pressure on every result
    drv(8'h78, 1, 0, 0, 0); drv(8'h79, 1, 0, 0, 0); drv(8'h7a, 1, 0, 0, 0);
    drv(8'h78, 0, 1, 1, 0);
    drv(8'h79, 0, 1, 0, 0); drv(8'h7a, 0, 1, 1, 0);
    drv(8'h7a, 0, 1, 1, 0);
    s0 = n_str; d0 = n_done;
    drv(8'h00, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      core_valid = 1'b1; core_match = k[0]; core_match_index = 5'(10 + k);
      wait_rv("multi rv");
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("multi hold p%0d", k), 32'({res_valid, res_match, res_index, res_pat_id, res_timeout}),
            32'({1'b1, k[0], 5'(10 + k), 2'(k), 1'b0}));
        step();
      end
      res_ready = 1'b1; step(); res_ready = 1'b0;
      chk("multi drop", 32'(res_valid), 32'd0);
    end
    core_valid = 1'b0;
    wait_done("multi done");
    step(); step();
    chk("multi done count", 32'(n_done - d0), 32'd1);
    chk("multi str cycles", 32'(n_str - s0), 32'd9);

    // pattern overflow: 10 bytes offered, 8 kept
    drv(8'h78, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drv(8'(8'h30 + i), 0, 1, i == 9, 0);
    chk("pat overflow", 32'(overflow), 32'd1);
    drv(8'h00, 0, 0, 0, 1);
    chk("go clears overflow", 32'(overflow), 32'd0);
    wait_pat("ovf pat start");
    n = 0;
    while (core_ispattern && n < 20) begin
      chk($sformatf("pat byte %0d", n), 32'(core_chardata), 32'(8'h30 + n));
      n++; step();
    end
    chk("pat cycles", 32'(n), 32'd8);
    core_valid = 1'b1; core_match = 1'b1; core_match_index = 5'd0;
    wait_rv("ovf rv");
    chk("ovf match", 32'(res_match), 32'd1);
    core_valid = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    wait_done("ovf done");
    step();

    // core never answers
    drv(8'h61, 1, 0, 0, 0); drv(8'h62, 0, 1, 1, 0);
    drv(8'h00, 0, 0, 0, 1);
    wait_pat("to pat start");
    n = 0;
    while (core_ispattern && n < 100) begin step(); n++; end
    chk("gap cycle", 32'({core_isstring, core_ispattern, core_chardata}), 32'd0);
    n = 0;
    while (!res_valid && n < 400) begin step(); n++; end
    chk("timeout latency", 32'(n), 32'd256);
    chk("timeout payload", 32'({res_valid, res_match, res_index, res_timeout}), 32'b1_0_00000_1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    wait_done("to done");
    step();

    // string limit, empty pattern, go with no patterns
    for (int i = 0; i < 32; i++) drv(8'h41, 1, 0, 0, 0);
    chk("str full no ovf", 32'(overflow), 32'd0);
    drv(8'h41, 1, 0, 0, 0);
    chk("str ovf", 32'(overflow), 32'd1);
    drv(8'h00, 0, 0, 1, 0);
    s0 = n_str;
    drv(8'h00, 0, 0, 0, 1);
    chk("empty go done", 32'({done, overflow}), 32'b10);
    step();
    chk("empty after", 32'({done, host_ready}), 32'b01);
    chk("empty no str", 32'(n_str - s0), 32'd0);
    drv(8'h55, 1, 1, 0, 0);
    chk("both flags ovf", 32'(overflow), 32'd1);

    // reset during SEND_PAT
    drv(8'h61, 1, 0, 0, 0); drv(8'h62, 1, 0, 0, 0);
    drv(8'h63, 0, 1, 0, 0); drv(8'h64, 0, 1, 0, 0); drv(8'h65, 0, 1, 0, 0); drv(8'h66, 0, 1, 1, 0);
    s0 = n_str;
    drv(8'h00, 0, 0, 0, 1);
    wait_pat("rst pat start");
    chk("rst str count", 32'(n_str - s0), 32'd2);
    d0 = n_done; r0 = n_rv;
    #2 reset = 1'b1;
    #1 chk("rst outputs", 32'(obs()), 32'd0);
    step();
    reset = 1'b0;
    #1 chk("rst ready", 32'(host_ready), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("rst no done", 32'(n_done - d0), 32'd0);
    chk("rst no rv", 32'(n_rv - r0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
